fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 15 +
 rtl/rr_select.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 142 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter.
//   - default parameter values (data width, requester count, burst length)
//   - arbiter FSM state encoding
package fifo_arb_pkg;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_BURST_LEN  = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// Round-robin pick: first asserted request at or after ptr, counting upward
// modulo NUM_REQ. Purely combinational.
// Ports:
//   req   in  NUM_REQ  request vector
//   ptr   in  IW       search start index (0..NUM_REQ-1)
//   idx   out IW       selected requester, valid when valid=1
//   valid out 1        at least one request asserted
module rr_select #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      idx,
    output logic               valid
);

    // Walk from the farthest offset down to offset 0 so the nearest hit wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NUM_REQ]) begin
                idx   = IW'((int'(ptr) + k) % NUM_REQ);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a synchronous FIFO. One requester owns
// the FIFO write port at a time for up to BURST_LEN beats; fifo_full stalls the
// owner without costing it beats or ownership.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req, req_data                 per-requester request and packed write data
//   gnt, accept                   current owner / beat taken this cycle
//   fifo_wr_en, fifo_data_in      FIFO write port
//   fifo_full, fifo_wr_ack,
//   fifo_overflow                 FIFO status
//   owner_id                      owner index, valid when |gnt
//   beat_count                    total accepted beats, wraps at 2^16
//   err_ack, err_overflow         sticky error flags, cleared only by rst
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | no owner, gnt=0, arbitrate from rr_ptr
// ST_OWN  | owner holds the write port, beats counted in burst_cnt
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int BURST_LEN  = DEF_BURST_LEN
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            accept,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic [$clog2(NUM_REQ)-1:0]    owner_id,
    output logic [15:0]                   beat_count,
    output logic                          err_ack,
    output logic                          err_overflow
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);

    arb_state_t    state;
    logic [IW-1:0] owner;
    logic [IW-1:0] rr_ptr;
    logic [BW-1:0] burst_cnt;
    logic          wr_en_q;

    logic [IW-1:0] owner_next;
    logic [IW-1:0] sel_ptr;
    logic [IW-1:0] sel_idx;
    logic          sel_valid;
    logic          release_own;

    assign owner_next = (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;

    // In OWN the selector only matters on release, when the search must start
    // just past the current owner; rr_ptr is that same value one cycle later.
    assign sel_ptr = (state == ST_OWN) ? owner_next : rr_ptr;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_select (
        .req   (req),
        .ptr   (sel_ptr),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    // accept is gated by rst so a reset landing mid-burst writes nothing.
    always_comb begin
        gnt    = '0;
        accept = '0;
        if (state == ST_OWN) begin
            gnt[owner] = 1'b1;
            if (!rst && req[owner] && !fifo_full) begin
                accept[owner] = 1'b1;
            end
        end
    end

    assign fifo_wr_en   = |accept;
    assign fifo_data_in = fifo_wr_en ? req_data[int'(owner)*FIFO_WIDTH +: FIFO_WIDTH] : '0;
    assign owner_id     = owner;

    assign release_own = !req[owner] || (fifo_wr_en && (burst_cnt == BURST_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            owner        <= '0;
            rr_ptr       <= '0;
            burst_cnt    <= '0;
            beat_count   <= '0;
            wr_en_q      <= 1'b0;
            err_ack      <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            wr_en_q <= fifo_wr_en;
            if (wr_en_q && !fifo_wr_ack) begin
                err_ack <= 1'b1;
            end
            if (fifo_overflow) begin
                err_overflow <= 1'b1;
            end
            if (fifo_wr_en) begin
                beat_count <= beat_count + 16'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        state     <= ST_OWN;
                        owner     <= sel_idx;
                        burst_cnt <= '0;
                    end
                end
                ST_OWN: begin
                    if (fifo_wr_en) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                    if (release_own) begin
                        rr_ptr <= owner_next;
                        if (sel_valid) begin
                            owner     <= sel_idx;
                            burst_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int W = 16;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   gnt;
    logic [N-1:0]   accept;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_data_in;
    logic           fifo_full;
    logic           fifo_wr_ack;
    logic           fifo_overflow;
    logic [1:0]     owner_id;
    logic [15:0]    beat_count;
    logic           err_ack;
    logic           err_overflow;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .FIFO_WIDTH (W),
        .NUM_REQ    (N),
        .BURST_LEN  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_data      (req_data),
        .gnt           (gnt),
        .accept        (accept),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_data_in  (fifo_data_in),
        .fifo_full     (fifo_full),
        .fifo_wr_ack   (fifo_wr_ack),
        .fifo_overflow (fifo_overflow),
        .owner_id      (owner_id),
        .beat_count    (beat_count),
        .err_ack       (err_ack),
        .err_overflow  (err_overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_data = '0;
        fifo_full = 1'b0; fifo_wr_ack = 1'b1; fifo_overflow = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL reset_gnt got %b want 0000", gnt); end
        vectors++; if (accept !== 4'b0000) begin miscompares++; $display("FAIL reset_accept got %b want 0000", accept); end
        vectors++; if (fifo_wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en got %b want 0", fifo_wr_en); end
        vectors++; if (fifo_data_in !== 16'h0) begin miscompares++; $display("FAIL reset_data got %h want 0000", fifo_data_in); end
        vectors++; if (beat_count !== 16'd0) begin miscompares++; $display("FAIL reset_beat_count got %0d want 0", beat_count); end
        vectors++; if (owner_id !== 2'd0) begin miscompares++; $display("FAIL reset_owner got %0d want 0", owner_id); end
        vectors++; if ({err_ack, err_overflow} !== 2'b00) begin miscompares++; $display("FAIL reset_err got %b want 00", {err_ack, err_overflow}); end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        req_data[2*W +: W] = 16'h2000;
        #1;
        vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL single_idle_gnt got %b want 0000", gnt); end
        tick();
        vectors++; if (gnt !== 4'b0100) begin miscompares++; $display("FAIL single_gnt got %b want 0100", gnt); end
        vectors++; if (owner_id !== 2'd2) begin miscompares++; $display("FAIL single_owner got %0d want 2", owner_id); end
        for (int b = 0; b < 3; b++) begin
            req_data[2*W +: W] = 16'h2000 + 16'(b);
            #1;
            vectors++; if (fifo_wr_en !== 1'b1 || accept !== 4'b0100) begin miscompares++; $display("FAIL single_beat%0d wr_en=%b accept=%b want 1 0100", b, fifo_wr_en, accept); end
            vectors++; if (fifo_data_in !== 16'h2000 + 16'(b)) begin miscompares++; $display("FAIL single_data%0d got %h want %h", b, fifo_data_in, 16'h2000 + 16'(b)); end
            tick();
        end
        req = 4'b0000;
        #1;
        vectors++; if (fifo_wr_en !== 1'b0) begin miscompares++; $display("FAIL single_drop_wr_en got %b want 0", fifo_wr_en); end
        vectors++; if (beat_count !== 16'd3) begin miscompares++; $display("FAIL single_beat_count got %0d want 3", beat_count); end
        tick();
        vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL single_release_gnt got %b want 0000", gnt); end
    endtask

    task automatic test_round_robin();
        int exp_owner [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 16'h1000 * 16'(i + 1);
        req = 4'b1111;
        tick();
        for (int o = 0; o < 5; o++) begin
            for (int b = 0; b < 4; b++) begin
                vectors++;
                if (gnt !== (4'b0001 << exp_owner[o]) || fifo_wr_en !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rr_slot%0d_beat%0d gnt=%b wr_en=%b want %b 1", o, b, gnt, fifo_wr_en, 4'b0001 << exp_owner[o]);
                end
                vectors++;
                if (fifo_data_in !== 16'h1000 * 16'(exp_owner[o] + 1)) begin
                    miscompares++;
                    $display("FAIL rr_data_slot%0d got %h want %h", o, fifo_data_in, 16'h1000 * 16'(exp_owner[o] + 1));
                end
                tick();
            end
        end
        vectors++; if (beat_count !== 16'd20) begin miscompares++; $display("FAIL rr_beat_count got %0d want 20", beat_count); end
        vectors++; if (gnt !== 4'b0010) begin miscompares++; $display("FAIL rr_next_owner got %b want 0010", gnt); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_full_stall();
        do_reset();
        req = 4'b0010;
        req_data[1*W +: W] = 16'h0B0B;
        tick();
        for (int b = 0; b < 2; b++) begin
            vectors++; if (fifo_wr_en !== 1'b1) begin miscompares++; $display("FAIL stall_pre%0d wr_en got %b want 1", b, fifo_wr_en); end
            tick();
        end
        fifo_full = 1'b1;
        for (int s = 0; s < 5; s++) begin
            #1;
            vectors++;
            if (fifo_wr_en !== 1'b0 || accept !== 4'b0000 || gnt !== 4'b0010) begin
                miscompares++;
                $display("FAIL stall_cyc%0d wr_en=%b accept=%b gnt=%b want 0 0000 0010", s, fifo_wr_en, accept, gnt);
            end
            tick();
        end
        fifo_full = 1'b0;
        vectors++; if (beat_count !== 16'd2) begin miscompares++; $display("FAIL stall_hold_count got %0d want 2", beat_count); end
        for (int b = 0; b < 2; b++) begin
            #1;
            vectors++; if (fifo_wr_en !== 1'b1 || accept !== 4'b0010) begin miscompares++; $display("FAIL stall_resume%0d wr_en=%b accept=%b want 1 0010", b, fifo_wr_en, accept); end
            tick();
        end
        req = 4'b0000;
        #1;
        vectors++; if (beat_count !== 16'd4) begin miscompares++; $display("FAIL stall_beat_count got %0d want 4", beat_count); end
        tick();
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 4'b0011;
        tick();
        vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL wd_first got %b want 0001", gnt); end
        tick();
        req = 4'b0001;
        tick(); tick(); tick();
        vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL wd_regrant got %b want 0001", gnt); end
        req = 4'b0000;
        tick();
        vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL wd_idle got %b want 0000", gnt); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req = 4'b1000;
        req_data[3*W +: W] = 16'h3333;
        tick();
        vectors++; if (gnt !== 4'b1000) begin miscompares++; $display("FAIL rmid_gnt got %b want 1000", gnt); end
        tick(); tick();
        vectors++; if (beat_count !== 16'd2) begin miscompares++; $display("FAIL rmid_pre_count got %0d want 2", beat_count); end
        rst = 1'b1;
        #1;
        vectors++; if (fifo_wr_en !== 1'b0 || accept !== 4'b0000) begin miscompares++; $display("FAIL rmid_rst_write wr_en=%b accept=%b want 0 0000", fifo_wr_en, accept); end
        tick();
        rst = 1'b0;
        #1;
        vectors++; if (gnt !== 4'b0000 || fifo_wr_en !== 1'b0) begin miscompares++; $display("FAIL rmid_post_gnt gnt=%b wr_en=%b want 0000 0", gnt, fifo_wr_en); end
        vectors++; if (beat_count !== 16'd0) begin miscompares++; $display("FAIL rmid_count got %0d want 0", beat_count); end
        tick();
        vectors++; if (gnt !== 4'b1000 || owner_id !== 2'd3) begin miscompares++; $display("FAIL rmid_regrant gnt=%b owner=%0d want 1000 3", gnt, owner_id); end
        req = 4'b0000;
        tick(); tick();
    endtask

    task automatic test_errors();
        do_reset();
        req = 4'b0001;
        tick();
        tick();
        req = 4'b0000;
        fifo_wr_ack = 1'b0;
        tick();
        fifo_wr_ack = 1'b1;
        #1;
        vectors++; if (err_ack !== 1'b1) begin miscompares++; $display("FAIL err_ack_set got %b want 1", err_ack); end
        vectors++; if (err_overflow !== 1'b0) begin miscompares++; $display("FAIL err_ovf_clear got %b want 0", err_overflow); end
        fifo_overflow = 1'b1;
        tick();
        fifo_overflow = 1'b0;
        tick(); tick(); tick();
        vectors++; if (err_overflow !== 1'b1) begin miscompares++; $display("FAIL err_ovf_sticky got %b want 1", err_overflow); end
        vectors++; if (err_ack !== 1'b1) begin miscompares++; $display("FAIL err_ack_sticky got %b want 1", err_ack); end
        do_reset();
        vectors++; if ({err_ack, err_overflow} !== 2'b00) begin miscompares++; $display("FAIL err_rst_clear got %b want 00", {err_ack, err_overflow}); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_withdraw();
        test_reset_mid_burst();
        test_errors();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
